// File: rtl/trig_pkg.sv
// Shared definitions for the trig datapath scheduler.
// Declares the datapath widths, the op encoding, the FSM state enum and the
// response payload struct that trig_sched registers.
package trig_pkg;

  localparam int unsigned ANGLE_W = 8;
  localparam int unsigned HEX_W   = 24;
  localparam int unsigned CNT_W   = 4;   // settle counter, covers 1..15

  localparam logic TRIG_SIN = 1'b0;
  localparam logic TRIG_COS = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_RESP
  } trig_state_e;

  typedef struct packed {
    logic             id;
    logic             neg;
    logic [HEX_W-1:0] hex;
  } trig_rsp_t;

endpackage

// File: rtl/trig_rr_arb2.sv
// Two-input round-robin arbiter.
// Ports: clk, resetn (sync, active-low); req0/req1 request levels;
// accept pulses when the current grant is taken, handing priority to the
// other requester; grant0_c/grant1_c combinational one-hot grants;
// grant_id_c the index of the granted requester.
module trig_rr_arb2 (
  input  logic clk,
  input  logic resetn,
  input  logic req0,
  input  logic req1,
  input  logic accept,
  output logic grant0_c,
  output logic grant1_c,
  output logic grant_id_c
);

  logic prio;  // 0: requester 0 wins a tie, 1: requester 1 wins a tie

  // Priority register: moves to the loser of each accepted grant
  always_ff @(posedge clk) begin
    if (!resetn) begin
      prio <= 1'b0;
    end else if (accept) begin
      prio <= ~grant_id_c;
    end
  end

  // Grant logic
  always_comb begin
    grant0_c   = req0 && (!req1 || !prio);
    grant1_c   = req1 && (!req0 ||  prio);
    grant_id_c = grant1_c;
  end

endmodule

// File: rtl/trig_sched.sv
// Round-robin scheduler for the shared combinational sine/cosine datapath.
// Ports: clk, resetn (sync, active-low);
//   reqN_valid/reqN_ready/reqN_op/reqN_angle: requester handshakes (N=0,1);
//   trig_angle: registered angle feeding both trig units;
//   sine_hex/sine_neg, cos_hex/cos_neg: trig unit results;
//   rsp_valid/rsp_ready/rsp_id/rsp_hex/rsp_neg: response port.
// The angle is held for SETTLE_CYCLES before the selected result is captured.
module trig_sched
  import trig_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic               req0_op,
  input  logic [ANGLE_W-1:0] req0_angle,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic               req1_op,
  input  logic [ANGLE_W-1:0] req1_angle,
  output logic [ANGLE_W-1:0] trig_angle,
  input  logic [HEX_W-1:0]   sine_hex,
  input  logic               sine_neg,
  input  logic [HEX_W-1:0]   cos_hex,
  input  logic               cos_neg,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic               rsp_id,
  output logic [HEX_W-1:0]   rsp_hex,
  output logic               rsp_neg
);

  trig_state_e      state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             lat_op;
  logic             lat_id;
  trig_rsp_t        rsp_q;
  logic             rsp_vld_q;

  logic             grant0_c, grant1_c, grant_id_c;
  logic             in_idle_c;
  logic             accept_c;
  trig_rsp_t        sel_c;

  trig_rr_arb2 u_arb (
    .clk        (clk),
    .resetn     (resetn),
    .req0       (req0_valid),
    .req1       (req1_valid),
    .accept     (accept_c),
    .grant0_c   (grant0_c),
    .grant1_c   (grant1_c),
    .grant_id_c (grant_id_c)
  );

  // Handshake decode; readies are forced low during reset
  always_comb begin
    in_idle_c  = resetn && (state == ST_IDLE);
    req0_ready = in_idle_c && grant0_c;
    req1_ready = in_idle_c && grant1_c;
    accept_c   = req0_ready || req1_ready;
  end

  // Result select from the unit matching the latched op
  always_comb begin
    sel_c.id  = lat_id;
    sel_c.hex = (lat_op == TRIG_COS) ? cos_hex : sine_hex;
    sel_c.neg = (lat_op == TRIG_COS) ? cos_neg : sine_neg;
  end

  // State register
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept_c) state_nxt = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (cnt == '0) state_nxt = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Request latch, settle counter and response capture
  always_ff @(posedge clk) begin
    if (!resetn) begin
      trig_angle <= '0;
      cnt        <= '0;
      lat_op     <= 1'b0;
      lat_id     <= 1'b0;
      rsp_q      <= '0;
      rsp_vld_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept_c) begin
            lat_op     <= grant_id_c ? req1_op    : req0_op;
            lat_id     <= grant_id_c;
            trig_angle <= grant_id_c ? req1_angle : req0_angle;
            cnt        <= CNT_W'(SETTLE_CYCLES - 1);
          end
        end
        ST_SETTLE: begin
          if (cnt == '0) begin
            rsp_q     <= sel_c;
            rsp_vld_q <= 1'b1;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_RESP: begin
          if (rsp_ready) rsp_vld_q <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

  assign rsp_valid = rsp_vld_q;
  assign rsp_id    = rsp_q.id;
  assign rsp_hex   = rsp_q.hex;
  assign rsp_neg   = rsp_q.neg;

endmodule

// File: doc/trig_sched.md
# trig_sched

Two-requester scheduler for the shared combinational sine/cosine datapath (one `mySine`, one `myCos`, 8-bit angle input, 256 steps per 2π, 24-bit six-digit hex-display output plus negative flag). It arbitrates round-robin between the keypad calculator path (requester 0) and the display sweep/demo path (requester 1). It drives a registered angle into both trig units and waits a fixed settle time. It then returns the selected function's result through a valid/ready response port.

## Interface
- `SETTLE_CYCLES`, 2: cycles the angle is held before the result is sampled; legal range 1..15.
- `clk` in 1: single clock, all logic on the rising edge.
- `resetn` in 1: synchronous, active-low reset.
- `req0_valid` in 1 / `req0_ready` out 1: requester 0 handshake.
- `req0_op` in 1: 0 = sine, 1 = cosine.
- `req0_angle` in 8: angle code.
- `req1_valid`, `req1_ready`, `req1_op`, `req1_angle`: same as requester 0, for requester 1.
- `trig_angle` out 8: registered angle to `sineIn`/`cosIn` of both trig units.
- `sine_hex` in 24 / `sine_neg` in 1: sine unit `hexOutput`/`negLedOut`.
- `cos_hex` in 24 / `cos_neg` in 1: cosine unit `hexOutput`/`negLedOut`.
- `rsp_valid` out 1 / `rsp_ready` in 1: response handshake.
- `rsp_id` out 1: requester served.
- `rsp_hex` out 24: captured digits, HEX5 at [23:20] … HEX0 at [3:0].
- `rsp_neg` out 1: captured negative flag.

## Operation
- FSM states: IDLE, SETTLE, RESP.
- IDLE:
  - Grant goes to the requester with `valid` high.
  - If both are high, grant goes to the priority holder.
  - `reqN_ready` = granted requester's `valid`. It is combinational and asserted in IDLE only; the other ready is 0.
  - A transfer occurs on `valid && ready`. On transfer:
    - latch op, id and angle;
    - `trig_angle` <= angle;
    - settle counter <= SETTLE_CYCLES-1;
    - go to SETTLE.
- Priority:
  - toggles to the non-granted requester on every accepted transfer;
  - an idle requester does not change it.
- SETTLE:
  - The counter decrements each cycle.
  - On the cycle the counter is 0:
    - capture `rsp_hex`/`rsp_neg` from cosine inputs if op = 1, otherwise from sine inputs;
    - set `rsp_valid`;
    - go to RESP.
- RESP:
  - `rsp_valid` and the `rsp_*` outputs are held stable until `rsp_ready`.
  - On `rsp_valid && rsp_ready`: clear `rsp_valid` and go to IDLE.
- `trig_angle` is held constant from acceptance until the next acceptance. It is never changed by RESP or IDLE.
- Requesters hold `op`/`angle` stable while `valid` is high and `ready` is low. The scheduler does not check this.
- Outputs on reset:
  - state IDLE, priority = requester 0;
  - `trig_angle` = 0, `rsp_valid` = 0, `rsp_id` = 0, `rsp_hex` = 0, `rsp_neg` = 0;
  - both readies 0 while `resetn` = 0.
- Reset mid-operation (SETTLE or RESP): the request is discarded with no response, and all outputs return to their reset values on the next edge.

## Timing
- Request accepted at edge T0. `trig_angle` is valid after T0.
- `rsp_valid` rises after edge T0+SETTLE_CYCLES. Default latency is 2 cycles accept-to-valid.
- `rsp_ready` high when `rsp_valid` rises: the response completes at that edge, IDLE is entered, and the next acceptance is possible one cycle later.
- Throughput: one result per SETTLE_CYCLES+2 cycles with zero response backpressure.
- `rsp_ready` held low: the FSM stays in RESP indefinitely, and both request readies stay 0.
- The trig datapath is combinational. SETTLE_CYCLES covers its multi-cycle path, which is constrained as such in timing.

## Structure
- Package `trig_pkg`:
  - `ANGLE_W` = 8, `HEX_W` = 24;
  - op constants `TRIG_SIN` = 0, `TRIG_COS` = 1;
  - FSM state enum `{ST_IDLE, ST_SETTLE, ST_RESP}`.
- Sub-module `trig_rr_arb2`: two-input round-robin grant with priority register and an advance-on-accept input.
- Settle counter, capture registers and result mux live in `trig_sched`.

## Test plan
Bench stubs for the trig units: `sine_hex` = {16'h5151, trig_angle}, `cos_hex` = {16'hC0C0, trig_angle}, `sine_neg` = trig_angle[7], `cos_neg` = ~trig_angle[7].

1. Reset: `resetn` low for 3 cycles with both valids high → both readies 0, `rsp_valid` 0, `trig_angle` 0; after release, requester 0 is granted first.
2. Single request: req0 sine, angle 8'h3F, `rsp_ready` = 1 → `rsp_valid` high 2 cycles after acceptance, `rsp_hex` 24'h51513F, `rsp_neg` 0, `rsp_id` 0.
3. Contention: both valid continuously; req0 cos angle 8'h7F, req1 sine angle 8'hFF → grants alternate 0,1,0,1. Req0 responses are 24'hC0C07F with `rsp_neg` 1. Req1 responses are 24'h5151FF with `rsp_neg` 1.
4. Backpressure: `rsp_ready` low for 10 cycles → `rsp_valid` and `rsp_hex` stable, readies 0, `trig_angle` unchanged; ready high → completes in 1 cycle.
5. Reset during SETTLE (req1, angle 8'h1F) → no response emitted; outputs at reset values; priority back to requester 0.
6. SETTLE_CYCLES = 5: angle 8'h00 → `rsp_valid` 5 cycles after acceptance, `rsp_hex` 24'h515100.
